conv_window_gen: RTL and testbench

- Sliding-window generator that sits directly upstream of the first 3x3 convolution stage.
- Accepts a raster-order pixel stream and buffers two full image rows in line buffers.
- Emits one registered 3x3xCH window per valid output position, packed in the convolution stage's input layout, with a one-cycle valid pulse.
- Valid (unpadded) convolution, stride 1.

---
 rtl/conv_window_gen.sv | 124 ++++++++++++
 tb/tb_conv_window_gen.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_gen.sv
// 3x3 sliding-window generator: two line buffers feed a 3x3 shift register, one window per pixel.
// Define CONV_WINDOW_STRIDE2_EN to emit only windows at even (r-2, c-2) offsets (stride 2).
module conv_window_gen #(
   parameter int unsigned IMG_W = 32,
   parameter int unsigned IMG_H = 32,
   parameter int unsigned CH    = 3,
   parameter int unsigned DW    = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic                 in_sof,
   input  logic [CH*DW-1:0]     in_act,
   output logic [9*CH*DW-1:0]   window_act,
   output logic                 window_valid,
   output logic                 frame_done,
   output logic                 frame_abort
);

   localparam int unsigned PW = CH * DW;
   localparam int unsigned CW = $clog2(IMG_W);
   localparam int unsigned RW = $clog2(IMG_H);

   typedef enum logic [1:0] {StIdle, StFill, StStream} state_e;

   state_e          state;
   logic [CW-1:0]   col;
   logic [RW-1:0]   row;
   logic [PW-1:0]   lb1 [IMG_W];
   logic [PW-1:0]   lb2 [IMG_W];
   logic [PW-1:0]   win [3][2];

   logic            restart;
   logic            abort;
   logic            emit;
   logic            col_last;
   logic            pos_last;
   logic [CW-1:0]   cur_col;
   logic [RW-1:0]   cur_row;
   logic [PW-1:0]   colv  [3];
   logic [PW-1:0]   taps  [3][3];
   logic [9*PW-1:0] win_next;

   always_comb begin
      // A pixel arriving with in_sof, or while idle, is always the frame origin
      restart  = in_sof || (state == StIdle);
      abort    = in_sof && (state != StIdle) && ((col != '0) || (row != '0));
      cur_col  = restart ? '0 : col;
      cur_row  = restart ? '0 : row;
      col_last = (cur_col == CW'(IMG_W - 1));
      pos_last = col_last && (cur_row == RW'(IMG_H - 1));
`ifdef CONV_WINDOW_STRIDE2_EN
      emit = (cur_row >= RW'(2)) && (cur_col >= CW'(2)) && !cur_row[0] && !cur_col[0];
`else
      emit = (cur_row >= RW'(2)) && (cur_col >= CW'(2));
`endif
      colv[0] = lb2[IMG_W-1];
      colv[1] = lb1[IMG_W-1];
      colv[2] = in_act;
      for (int ky = 0; ky < 3; ky++) begin
         taps[ky][0] = win[ky][0];
         taps[ky][1] = win[ky][1];
         taps[ky][2] = colv[ky];
      end
      win_next = '0;
      for (int ch = 0; ch < int'(CH); ch++) begin
         for (int ky = 0; ky < 3; ky++) begin
            for (int kx = 0; kx < 3; kx++) begin
               win_next[(9*ch + 3*ky + kx)*DW +: DW] = taps[ky][kx][ch*DW +: DW];
            end
         end
      end
   end

   // Data path carries no reset: contents are always refilled before being emitted
   always_ff @(posedge clk) begin
      if (in_valid) begin
         lb1[0] <= in_act;
         lb2[0] <= lb1[IMG_W-1];
         for (int i = 1; i < int'(IMG_W); i++) begin
            lb1[i] <= lb1[i-1];
            lb2[i] <= lb2[i-1];
         end
         for (int ky = 0; ky < 3; ky++) begin
            win[ky][0] <= win[ky][1];
            win[ky][1] <= colv[ky];
         end
      end
   end

   always_ff @(posedge clk) begin
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
      frame_abort  <= 1'b0;
      if (rst) begin
         state      <= StIdle;
         col        <= '0;
         row        <= '0;
         window_act <= '0;
      end else if (in_valid) begin
         frame_abort <= abort;
         if (emit) begin
            window_valid <= 1'b1;
            window_act   <= win_next;
         end
         if (pos_last) begin
            frame_done <= 1'b1;
            state      <= StIdle;
            col        <= '0;
            row        <= '0;
         end else begin
            state <= (cur_row >= RW'(2)) ? StStream : StFill;
            if (col_last) begin
               col <= '0;
               row <= cur_row + RW'(1);
            end else begin
               col <= cur_col + CW'(1);
               row <= cur_row;
            end
         end
      end
   end

endmodule

// File: tb/tb_conv_window_gen.sv
// Randomized bench for conv_window_gen: outputs compared every cycle against a frame-image model.
module tb_conv_window_gen;

   localparam int unsigned IMG_W = 8;
   localparam int unsigned IMG_H = 8;
   localparam int unsigned CH    = 3;
   localparam int unsigned DW    = 16;
   localparam int unsigned PW    = CH * DW;
   localparam int unsigned WW    = 9 * PW;
`ifdef CONV_WINDOW_STRIDE2_EN
   localparam int NWIN = 9;
`else
   localparam int NWIN = 36;
`endif

   typedef logic [PW-1:0] pix_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_sof = 1'b0;
   pix_t          in_act = '0;
   logic [WW-1:0] window_act;
   logic          window_valid;
   logic          frame_done;
   logic          frame_abort;

   conv_window_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .CH(CH), .DW(DW)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_sof       (in_sof),
      .in_act       (in_act),
      .window_act   (window_act),
      .window_valid (window_valid),
      .frame_done   (frame_done),
      .frame_abort  (frame_abort)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_bad = 0;
   int n_win, n_done, n_abort;

   // Reference model: the received frame as an image, positions tracked arithmetically
   pix_t          img [IMG_H][IMG_W];
   bit            m_active = 0;
   int            m_r = 0, m_c = 0, m_widx = 0;
   logic          e_valid, e_done, e_abort;
   logic [WW-1:0] e_win = '0;
   int            e_widx;
   bit            pat_data;

   task automatic check_eq(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic pix_t mk_pix(input int r, input int c);
      pix_t p;
      p[0*DW +: DW] = DW'(r*8 + c);
      p[1*DW +: DW] = DW'(100 + r*8 + c);
      p[2*DW +: DW] = DW'(200 + r*8 + c);
      return p;
   endfunction

   task automatic model(input logic v, input logic s, input logic r, input pix_t px);
      int   pr, pc;
      pix_t p;
      bit   emit;
      e_valid = 0; e_done = 0; e_abort = 0;
      if (r) begin
         m_active = 0; m_r = 0; m_c = 0; e_win = '0;
         return;
      end
      if (!v) return;
      if (s || !m_active) begin
         e_abort = s && m_active && (m_r != 0 || m_c != 0);
         pr = 0; pc = 0; m_widx = 0;
      end else begin
         pr = m_r; pc = m_c;
      end
      img[pr][pc] = px;
      emit = (pr >= 2) && (pc >= 2);
`ifdef CONV_WINDOW_STRIDE2_EN
      emit = emit && ((pr - 2) % 2 == 0) && ((pc - 2) % 2 == 0);
`endif
      if (emit) begin
         for (int ch = 0; ch < int'(CH); ch++)
            for (int ky = 0; ky < 3; ky++)
               for (int kx = 0; kx < 3; kx++) begin
                  p = img[pr-2+ky][pc-2+kx];
                  e_win[(9*ch + 3*ky + kx)*DW +: DW] = p[ch*DW +: DW];
               end
         e_valid = 1;
         e_widx  = m_widx;
         m_widx++;
      end
      if (pr == int'(IMG_H) - 1 && pc == int'(IMG_W) - 1) begin
         e_done = 1; m_active = 0; m_r = 0; m_c = 0;
      end else begin
         m_active = 1;
         m_c = (pc + 1) % int'(IMG_W);
         m_r = (pc == int'(IMG_W) - 1) ? pr + 1 : pr;
      end
   endtask

   task automatic cycle(input logic v, input logic s, input logic r, input pix_t px);
      logic [DW-1:0] tap;
      int            ref0 [9];
      ref0 = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
      in_valid = v; in_sof = s; rst = r; in_act = px;
      model(v, s, r, px);
      @(posedge clk);
      #1;
      in_valid = 0; in_sof = 0; rst = 0;
      check_eq("window_valid", WW'(window_valid), WW'(e_valid));
      check_eq("frame_done", WW'(frame_done), WW'(e_done));
      check_eq("frame_abort", WW'(frame_abort), WW'(e_abort));
      check_eq("window_act", window_act, e_win);
      if (window_valid) n_win++;
      if (frame_done) n_done++;
      if (frame_abort) n_abort++;
      if (e_valid && pat_data && e_widx == 0) begin
         for (int k = 0; k < 9; k++) begin
            tap = window_act[k*DW +: DW];
            check_eq("first_ch0_tap", WW'(tap), WW'(ref0[k]));
         end
         tap = window_act[(18 + 8)*DW +: DW];
         check_eq("first_ch2_tap8", WW'(tap), WW'(218));
      end
      if (e_valid && pat_data && e_widx == 1) begin
         tap = window_act[8*DW +: DW];
`ifdef CONV_WINDOW_STRIDE2_EN
         check_eq("second_ch0_tap8", WW'(tap), WW'(20));
`else
         check_eq("second_ch0_tap8", WW'(tap), WW'(19));
`endif
      end
   endtask

   // Sends a frame in raster order, stopping before (stop_r, stop_c) when stop_r >= 0
   task automatic send_frame(input bit sof, input int unsigned gap, input bit rnd,
                             input int stop_r, input int stop_c);
      pix_t px;
      pat_data = !rnd;
      for (int r = 0; r < int'(IMG_H); r++) begin
         for (int c = 0; c < int'(IMG_W); c++) begin
            if (r == stop_r && c == stop_c) return;
            while ($urandom_range(99) < gap) cycle(1'b0, 1'b0, 1'b0, pix_t'($urandom()));
            px = rnd ? pix_t'({$urandom(), $urandom()}) : mk_pix(r, c);
            cycle(1'b1, sof && r == 0 && c == 0, 1'b0, px);
         end
      end
   endtask

   task automatic clear_counts();
      n_win = 0; n_done = 0; n_abort = 0;
   endtask

   task automatic check_counts(input string tag, input int wins, input int dones, input int aborts);
      check_eq({tag, "_wins"}, WW'(n_win), WW'(wins));
      check_eq({tag, "_dones"}, WW'(n_done), WW'(dones));
      check_eq({tag, "_aborts"}, WW'(n_abort), WW'(aborts));
   endtask

   initial begin
      clear_counts();
      pat_data = 1;
      cycle(1'b0, 1'b0, 1'b1, '0);
      cycle(1'b1, 1'b1, 1'b1, mk_pix(0, 0));

      // contiguous frame
      clear_counts();
      send_frame(1'b1, 0, 1'b0, -1, -1);
      cycle(1'b0, 1'b0, 1'b0, '0);
      check_counts("contig", NWIN, 1, 0);

      // ~50% gaps
      clear_counts();
      send_frame(1'b1, 50, 1'b0, -1, -1);
      check_counts("gaps", NWIN, 1, 0);

      // back-to-back frames
      clear_counts();
      send_frame(1'b1, 0, 1'b0, -1, -1);
      send_frame(1'b1, 0, 1'b0, -1, -1);
      check_counts("b2b", 2 * NWIN, 2, 0);

      // mid-frame sof at (4,3)
      send_frame(1'b1, 0, 1'b0, 4, 3);
      clear_counts();
      send_frame(1'b1, 0, 1'b0, -1, -1);
      check_counts("abort", NWIN, 1, 1);

      // reset at (3,5)
      send_frame(1'b1, 20, 1'b0, 3, 5);
      cycle(1'b1, 1'b0, 1'b1, mk_pix(3, 5));
      check_eq("rst_act", window_act, '0);
      clear_counts();
      send_frame(1'b0, 0, 1'b0, -1, -1);
      check_counts("after_rst", NWIN, 1, 0);

      // random data, random gaps, frames started from idle without sof
      for (int f = 0; f < 3; f++) begin
         clear_counts();
         send_frame(f[0], 30, 1'b1, -1, -1);
         check_counts("rand", NWIN, 1, 0);
      end
      cycle(1'b0, 1'b0, 1'b0, '0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
